// File: rtl/sd_block_responder.sv
// Slave-side SD card stand-in: answers the sdspihost command/busy handshake and
// serves or stores 512-byte blocks from a local byte memory with a backdoor port.
module sd_block_responder #(
  parameter int          NUM_BLOCKS    = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h00100000,
  parameter int          INIT_CYCLES   = 16,
  parameter int          BLOCK_CYCLES  = 8,
  parameter int          BYTE_CYCLES   = 4,
  parameter int          COMMIT_CYCLES = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                spi_rst,
  input  logic                                spi_r_block,
  input  logic                                spi_r_byte,
  input  logic                                spi_r_multi_block,
  input  logic                                spi_w_block,
  input  logic                                spi_w_byte,
  input  logic [31:0]                         spi_block_addr,
  input  logic [7:0]                          spi_data_in,
  output logic [7:0]                          spi_data_out,
  output logic                                spi_busy,
  output logic                                spi_err,
  output logic                                spi_crc_err,
  input  logic                                bd_we,
  input  logic [$clog2(NUM_BLOCKS*512)-1:0]   bd_addr,
  input  logic [7:0]                          bd_din,
  output logic [7:0]                          bd_dout
);

  localparam int BW    = $clog2(NUM_BLOCKS);
  localparam int AW    = BW + 9;
  localparam int DEPTH = NUM_BLOCKS * 512;

  localparam logic [15:0] INIT_N   = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] BLOCK_N  = 16'(BLOCK_CYCLES - 1);
  localparam logic [15:0] BYTE_N   = 16'(BYTE_CYCLES - 1);
  localparam logic [15:0] COMMIT_N = 16'(COMMIT_CYCLES - 1);

  typedef enum logic [3:0] {
    UNINIT, INIT, READY, RD_OPEN_WAIT, RD_OPEN, RD_BYTE,
    WR_OPEN_WAIT, WR_OPEN, WR_BYTE, WR_COMMIT, ERR
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [9:0]      ptr_q, ptr_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [7:0]      dout_q, dout_d;
  logic            err_q, err_d;
  logic [7:0]      bd_dout_q;
  logic            wr_en;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     rel;
  logic [7:0]      mem [DEPTH];

  assign mem_addr = {blk_q, ptr_q[8:0]};
  // Unsigned difference: addresses below BASE_ADDR wrap to huge values and fail the range test.
  assign rel      = spi_block_addr - BASE_ADDR;

  function automatic logic [9:0] ptr_inc(input logic [9:0] p);
    return (p == 10'h3FF) ? p : p + 10'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNINIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      blk_q   <= '0;
      dout_q  <= 8'hFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      blk_q   <= blk_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
    ptr_d   = ptr_q;
    blk_d   = blk_q;
    dout_d  = dout_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      UNINIT: if (spi_rst) begin
        state_d = INIT; cnt_d = INIT_N; err_d = 1'b0;
      end
      INIT: if (cnt_q == '0) state_d = READY;
      READY: begin
        if (spi_rst) begin
          state_d = INIT; cnt_d = INIT_N; err_d = 1'b0;
        end else if (spi_r_multi_block) begin
          state_d = ERR; err_d = 1'b1;
        end else if (spi_r_block || spi_w_block) begin
          blk_d = rel[BW-1:0];
          ptr_d = '0;
          cnt_d = BLOCK_N;
          if (rel >= 32'(NUM_BLOCKS)) begin
            state_d = ERR; err_d = 1'b1;
          end else begin
            state_d = spi_r_block ? RD_OPEN_WAIT : WR_OPEN_WAIT;
          end
        end
      end
      RD_OPEN_WAIT: if (cnt_q == '0) begin
        state_d = RD_OPEN; dout_d = mem[mem_addr];
      end
      RD_OPEN: begin
        if (!spi_r_block) state_d = READY;
        else if (spi_rst) begin
          state_d = INIT; cnt_d = INIT_N; err_d = 1'b0;
        end else if (spi_r_byte) begin
          state_d = RD_BYTE; cnt_d = BYTE_N; ptr_d = ptr_inc(ptr_q);
        end
      end
      // Past the end of the block the card returns idle-bus 0xFF.
      RD_BYTE: if (cnt_q == '0) begin
        state_d = RD_OPEN; dout_d = ptr_q[9] ? 8'hFF : mem[mem_addr];
      end
      WR_OPEN_WAIT: if (cnt_q == '0) state_d = WR_OPEN;
      WR_OPEN: begin
        if (!spi_w_block) begin
          state_d = WR_COMMIT; cnt_d = COMMIT_N;
        end else if (spi_rst) begin
          state_d = INIT; cnt_d = INIT_N; err_d = 1'b0;
        end else if (spi_w_byte) begin
          state_d = WR_BYTE; cnt_d = BYTE_N;
        end
      end
      // Bytes beyond 511 are CRC/token traffic and are dropped.
      WR_BYTE: if (cnt_q == '0) begin
        state_d = WR_OPEN; wr_en = ~ptr_q[9] & ~rst; ptr_d = ptr_inc(ptr_q);
      end
      WR_COMMIT: if (cnt_q == '0) state_d = READY;
      ERR: if (spi_rst) begin
        state_d = INIT; cnt_d = INIT_N; err_d = 1'b0;
      end
      default: state_d = UNINIT;
    endcase
  end

  always_comb begin
    spi_busy = 1'b0;
    case (state_q)
      INIT, RD_OPEN_WAIT, RD_BYTE, WR_OPEN_WAIT, WR_BYTE, WR_COMMIT: spi_busy = 1'b1;
      default: spi_busy = 1'b0;
    endcase
    spi_err      = err_q;
    spi_crc_err  = 1'b0;
    spi_data_out = dout_q;
    bd_dout      = bd_dout_q;
  end

  // Responder store is issued last so it wins over a same-address backdoor write.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_din;
    if (wr_en) mem[mem_addr] <= spi_data_in;
    bd_dout_q <= rst ? 8'h00 : mem[bd_addr];
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: init, block read/write, range errors,
// read past end of block and reset during a byte write.
`timescale 1ns/1ps
module tb_sd_block_responder;

  localparam logic [31:0] BASE = 32'h00100000;

  logic        clk = 1'b0;
  logic        rst, spi_rst, spi_r_block, spi_r_byte, spi_r_multi_block;
  logic        spi_w_block, spi_w_byte;
  logic [31:0] spi_block_addr;
  logic [7:0]  spi_data_in, spi_data_out;
  logic        spi_busy, spi_err, spi_crc_err;
  logic        bd_we;
  logic [10:0] bd_addr;
  logic [7:0]  bd_din, bd_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_block_responder dut (
    .clk(clk), .rst(rst), .spi_rst(spi_rst), .spi_r_block(spi_r_block),
    .spi_r_byte(spi_r_byte), .spi_r_multi_block(spi_r_multi_block),
    .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte),
    .spi_block_addr(spi_block_addr), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_err(spi_err),
    .spi_crc_err(spi_crc_err), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_din(bd_din), .bd_dout(bd_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (spi_busy && n < 5000) begin
      n++;
      step();
    end
  endtask

  task automatic bd_write(input int a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = 11'(a); bd_din = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input int a, output logic [7:0] d);
    bd_addr = 11'(a);
    step();
    d = bd_dout;
  endtask

  task automatic do_init(output int n);
    spi_rst = 1'b1;
    step();
    spi_rst = 1'b0;
    busy_len(n);
  endtask

  task automatic rd_byte(output int n);
    spi_r_byte = 1'b1;
    step();
    spi_r_byte = 1'b0;
    busy_len(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, bad_busy;
    logic [7:0] d, exp_d;
    rst = 1'b1; spi_rst = 0; spi_r_block = 0; spi_r_byte = 0; spi_r_multi_block = 0;
    spi_w_block = 0; spi_w_byte = 0; spi_block_addr = BASE; spi_data_in = 0;
    bd_we = 0; bd_addr = 0; bd_din = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", spi_busy, 0);
    chk("rst_err", spi_err, 0);
    chk("rst_crc", spi_crc_err, 0);
    chk("rst_dout", spi_data_out, 8'hFF);
    chk("rst_bd_dout", bd_dout, 8'h00);

    // Requests other than spi_rst are ignored before init
    spi_r_block = 1'b1;
    step(); step(); step();
    chk("uninit_busy", spi_busy, 0);
    spi_r_block = 1'b0;

    bd_write(0, 8'hAA); bd_write(1, 8'hBB); bd_write(2, 8'hCC); bd_write(3, 8'hDD);
    bd_write(1024, 8'h5A); bd_write(1025, 8'h5B); bd_write(1026, 8'h5C);
    bd_read(2, d);
    chk("bd_readback", d, 8'hCC);

    do_init(n);
    chk("init_len", n, 16);

    // Block 0 read session
    spi_block_addr = BASE; spi_r_block = 1'b1;
    step();
    busy_len(n);
    chk("rd_open_len", n, 8);
    chk("rd_byte0", spi_data_out, 8'hAA);
    rd_byte(n); chk("rd_b1_len", n, 4); chk("rd_b1", spi_data_out, 8'hBB);
    rd_byte(n); chk("rd_b2_len", n, 4); chk("rd_b2", spi_data_out, 8'hCC);
    rd_byte(n); chk("rd_b3_len", n, 4); chk("rd_b3", spi_data_out, 8'hDD);
    spi_r_block = 1'b0;
    step();
    chk("rd_close_busy", spi_busy, 0);

    // Block 1 write session with 3 trailing bytes that must be discarded
    spi_block_addr = BASE + 1; spi_w_block = 1'b1;
    step();
    busy_len(n);
    chk("wr_open_len", n, 8);
    bad_busy = 0;
    for (int i = 0; i < 515; i++) begin
      spi_data_in = 8'(i);
      spi_w_byte = 1'b1;
      step();
      spi_w_byte = 1'b0;
      busy_len(n);
      if (n != 4) bad_busy++;
    end
    chk("wr_byte_lens", bad_busy, 0);
    spi_w_block = 1'b0;
    step();
    busy_len(n);
    chk("commit_len", n, 32);

    bad = 0;
    for (int j = 0; j < 512; j++) begin
      bd_read(512 + j, d);
      exp_d = 8'(j);
      if (d !== exp_d) bad++;
    end
    chk("blk1_contents", bad, 0);
    bd_read(512 + 300, d); chk("blk1_b300", d, 8'h2C);
    bd_read(1024, d); chk("blk2_b0", d, 8'h5A);
    bd_read(1025, d); chk("blk2_b1", d, 8'h5B);
    bd_read(1026, d); chk("blk2_b2", d, 8'h5C);

    // Out-of-range block above the window
    spi_block_addr = BASE + 4; spi_r_block = 1'b1;
    step();
    chk("oor_err", spi_err, 1);
    chk("oor_busy", spi_busy, 0);
    step(); step();
    chk("err_ignore_busy", spi_busy, 0);
    spi_r_block = 1'b0;
    do_init(n);
    chk("err_init_len", n, 16);
    chk("err_cleared", spi_err, 0);

    // Block address below the base wraps and is out of range
    spi_block_addr = BASE - 1; spi_w_block = 1'b1;
    step();
    chk("below_err", spi_err, 1);
    spi_w_block = 1'b0;
    do_init(n);

    spi_r_multi_block = 1'b1;
    step();
    chk("multi_err", spi_err, 1);
    chk("multi_busy", spi_busy, 0);
    spi_r_multi_block = 1'b0;
    do_init(n);
    chk("multi_cleared", spi_err, 0);

    // Read past end: byte 511 marked so 0xFF afterwards is distinguishable
    bd_write(512 + 511, 8'h77);
    spi_block_addr = BASE + 1; spi_r_block = 1'b1;
    step();
    busy_len(n);
    chk("pe_byte0", spi_data_out, 8'h00);
    bad = 0;
    for (int k = 1; k <= 1030; k++) begin
      rd_byte(n);
      if (k < 511) exp_d = 8'(k);
      else if (k == 511) exp_d = 8'h77;
      else exp_d = 8'hFF;
      if (spi_data_out !== exp_d || n != 4) bad++;
      if (k == 510) chk("pe_b510", spi_data_out, 8'hFE);
      if (k == 511) chk("pe_b511", spi_data_out, 8'h77);
      if (k == 512) chk("pe_b512", spi_data_out, 8'hFF);
    end
    chk("pe_sweep", bad, 0);
    chk("pe_sat_dout", spi_data_out, 8'hFF);
    spi_r_block = 1'b0;
    step();

    // rst during the second byte of a write session
    spi_block_addr = BASE + 3; spi_w_block = 1'b1;
    step();
    busy_len(n);
    spi_data_in = 8'h11; spi_w_byte = 1'b1;
    step();
    spi_w_byte = 1'b0;
    busy_len(n);
    spi_data_in = 8'h22; spi_w_byte = 1'b1;
    step();
    spi_w_byte = 1'b0;
    chk("mid_busy_pre", spi_busy, 1);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", spi_busy, 0);
    rst = 1'b0; spi_w_block = 1'b0;
    chk("mid_rst_dout", spi_data_out, 8'hFF);
    spi_r_block = 1'b1; spi_block_addr = BASE;
    step(); step();
    chk("mid_uninit_busy", spi_busy, 0);
    spi_r_block = 1'b0;
    bd_read(1536, d); chk("mid_kept_b3", d, 8'h11);
    bd_read(512 + 5, d); chk("mid_kept_b1", d, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_block_responder.md
# sd_block_responder

Behavioural SD-card stand-in that answers the sdspihost command/busy handshake from the slave side. It serves 512-byte blocks from an internal byte memory to a requesting FSM and accepts block writes back into that memory. A backdoor port lets the bench or surrounding logic preload and inspect the contents. It replaces the physical card in autotest closed-loop simulation and FPGA self-test builds.

## Interface
- NUM_BLOCKS, 4: blocks held; memory = NUM_BLOCKS*512 bytes
- BASE_ADDR, 32'h00100000: block address mapped to local block 0
- INIT_CYCLES, 16: busy length of init
- BLOCK_CYCLES, 8: busy length of read/write block open
- BYTE_CYCLES, 4: busy length per byte (minimum 2)
- COMMIT_CYCLES, 32: busy length of write commit
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; memory contents not cleared
- spi_rst  in  1  init request (level)
- spi_r_block  in  1  read session request, held for whole session
- spi_r_byte  in  1  advance to next read byte
- spi_r_multi_block  in  1  unsupported; raises spi_err
- spi_w_block  in  1  write session request, held for whole session
- spi_w_byte  in  1  write one byte from spi_data_in
- spi_block_addr  in  32  absolute block address
- spi_data_in  in  8  write data
- spi_data_out  out  8  current read byte
- spi_busy  out  1  operation in progress
- spi_err  out  1  sticky error
- spi_crc_err  out  1  always 0
- bd_we  in  1  backdoor write strobe
- bd_addr  in  clog2(NUM_BLOCKS*512)  backdoor byte address
- bd_din  in  8  backdoor write data
- bd_dout  out  8  backdoor read data, 1-cycle latency

## Operation
- States: UNINIT, INIT, READY, RD_OPEN_WAIT, RD_OPEN, RD_BYTE, WR_OPEN_WAIT, WR_OPEN, WR_BYTE, WR_COMMIT, ERR.
- UNINIT: all requests except spi_rst ignored. spi_rst=1 -> INIT.
- INIT: busy INIT_CYCLES -> READY; clears spi_err.
- READY: priority spi_rst > spi_r_multi_block > spi_r_block > spi_w_block.
  - spi_rst -> INIT.
  - r_multi_block -> ERR.
  - r_block/w_block: latch blk = spi_block_addr - BASE_ADDR; blk >= NUM_BLOCKS (unsigned, wrap below base counts as out of range) -> ERR; else ptr=0 -> RD_OPEN_WAIT / WR_OPEN_WAIT.
- RD_OPEN_WAIT: busy BLOCK_CYCLES, then spi_data_out = mem[blk][0] -> RD_OPEN.
- RD_OPEN:
  - r_block=0 -> READY.
  - spi_rst -> INIT.
  - r_byte=1 -> RD_BYTE: ptr+1; on exit spi_data_out = mem[blk][ptr], or 8'hFF when ptr >= 512.
- WR_OPEN_WAIT: busy BLOCK_CYCLES -> WR_OPEN.
- WR_OPEN:
  - w_block=0 -> WR_COMMIT.
  - spi_rst -> INIT, no commit; bytes already stored remain.
  - w_byte=1 -> WR_BYTE.
- WR_BYTE: samples spi_data_in in last busy cycle; ptr<512 -> mem[blk][ptr]=data, else discarded (CRC/token bytes); ptr+1.
- WR_COMMIT: busy COMMIT_CYCLES -> READY.
- ptr: 10 bits, saturates at 1023.
- ERR: spi_err=1, busy 0, only spi_rst accepted -> INIT.
- Requests are level-sensitive. A requester must drop r_byte/w_byte before busy falls, or a second byte operation starts.
- Backdoor bd_we has lower priority than a same-cycle WR_BYTE store to the same address: the responder write wins.

## Timing
- Reset values: state UNINIT, spi_busy 0, spi_err 0, spi_crc_err 0, spi_data_out 8'hFF, ptr 0, bd_dout 8'h00.
- Request seen at clock edge k -> spi_busy=1 from k+1 for exactly N cycles (N = the relevant *_CYCLES), then 0.
- spi_data_out is valid in the same cycle busy falls and holds until the next read byte completes.
- spi_data_in must be stable from busy rise +1 through busy fall.
- Requests are not sampled in a cycle where spi_busy=1.
- Session close (r_block low) takes 1 cycle to reach READY.
- rst mid-operation: immediate UNINIT; memory contents kept.

## Test plan
- rst, spi_rst 1 cycle -> busy high exactly 16 cycles; r_block before init -> busy stays 0.
- Preload mem[0][0..3]=AA BB CC DD via backdoor; init; r_block addr 32'h00100000 -> after busy(8) data_out=AA; three r_byte -> BB, CC, DD, each busy exactly 4 cycles.
- Write session to 32'h00100001 with 515 w_byte of values i[7:0], then drop w_block -> busy 32 cycles; backdoor reads of block 1 give bytes 0..511 = i; block 2 untouched.
- r_block addr 32'h00100004 -> spi_err=1, busy 0; r_block ignored; spi_rst -> spi_err cleared after init.
- Read past end: 512 r_byte -> last data_out 8'hFF; ptr saturates, no wrap to byte 0.
- rst asserted mid-WR_BYTE -> next cycle busy 0, state UNINIT; previously written bytes still readable via backdoor.
